exec_stage_param: RTL

//   Parametrised decode/execute pipeline stage: accepts one 32-bit MIPS-style instruction per handshake,

---
 rtl/exec_stage_param.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/exec_stage_param.sv
// exec_stage_param -- decode/execute stage for 32-bit MIPS-style instructions.
//
// Accepts one instruction per upstream handshake and reads two operands from a
// 2**RADDR_W-entry register file. It executes one R-type or I-type ALU op,
// writes the result back and presents it downstream until it is acknowledged.
//
// Optional feature macro: OVERFLOW_TRAP_EN
//   defined   : signed overflow on add/sub/addi raises trap and suppresses writeback
//   undefined : trap is tied low and overflowing results are written back wrapped
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   DIR / ack_prev      upstream valid / one-cycle accept pulse
//   data_in[31:0]       instruction word
//   DOR / ack_from_next downstream valid / consume
//   data_out, dest_out  result value and destination register index
//   illegal, trap       result qualifiers, meaningful while DOR=1
//   dbg_raddr/dbg_rdata combinational register file peek (index 0 reads 0)
module exec_stage_param #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               DIR,
  output logic               ack_prev,
  input  logic [31:0]        data_in,
  output logic               DOR,
  input  logic               ack_from_next,
  output logic [DATA_W-1:0]  data_out,
  output logic [RADDR_W-1:0] dest_out,
  output logic               illegal,
  output logic               trap,
  input  logic [RADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);

  localparam int DEPTH = 1 << RADDR_W;
  localparam int SH_W  = $clog2(DATA_W);
  localparam int M     = DATA_W - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]        r_state;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_s, r_t, r_d;
  logic [4:0]        r_dest5;
  logic              r_ill, r_trp;
  logic [DATA_W-1:0] r_rf [DEPTH];

  // Instruction fields carry 5-bit indices; those beyond the configured depth
  // read as zero and are never written.
  function automatic logic in_range(input logic [4:0] f);
    return (32'(f) >> RADDR_W) == 32'd0;
  endfunction

  function automatic logic [RADDR_W-1:0] to_idx(input logic [4:0] f);
    return RADDR_W'(f);
  endfunction

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd, w_shamt;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_imm_sx, w_imm_zx, w_add, w_sub, w_addi;
  logic [DATA_W-1:0] w_d;
  logic [4:0]        w_dest5;
  logic              w_ill, w_trap, w_we;

  assign w_op     = r_instr[31:26];
  assign w_rs     = r_instr[25:21];
  assign w_rt     = r_instr[20:16];
  assign w_rd     = r_instr[15:11];
  assign w_shamt  = r_instr[10:6];
  assign w_funct  = r_instr[5:0];
  assign w_imm    = r_instr[15:0];
  assign w_imm_sx = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_imm_zx = {{(DATA_W-16){1'b0}}, w_imm};
  assign w_add    = r_s + r_t;
  assign w_sub    = r_s - r_t;
  assign w_addi   = r_s + w_imm_sx;

  always_comb begin
    w_d     = '0;
    w_ill   = 1'b0;
    w_dest5 = (w_op == 6'h00) ? w_rd : w_rt;
    if (w_op == 6'h00) begin
      case (w_funct)
        6'h00: w_d = r_t << w_shamt;
        6'h02: w_d = r_t >> w_shamt;
        6'h03: w_d = $signed(r_t) >>> w_shamt;
        6'h04: w_d = r_t << r_s[SH_W-1:0];
        6'h20, 6'h21: w_d = w_add;
        6'h22, 6'h23: w_d = w_sub;
        6'h24: w_d = r_s & r_t;
        6'h25: w_d = r_s | r_t;
        6'h26: w_d = r_s ^ r_t;
        6'h27: w_d = ~(r_s | r_t);
        6'h2A: w_d = DATA_W'($signed(r_s) < $signed(r_t));
        6'h2B: w_d = DATA_W'(r_s < r_t);
        default: w_ill = 1'b1;
      endcase
    end else begin
      case (w_op)
        6'h08, 6'h09: w_d = w_addi;
        6'h0A: w_d = DATA_W'($signed(r_s) < $signed(w_imm_sx));
        6'h0B: w_d = DATA_W'(r_s < w_imm_sx);
        6'h0C: w_d = r_s & w_imm_zx;
        6'h0D: w_d = r_s | w_imm_zx;
        6'h0E: w_d = r_s ^ w_imm_zx;
        // sign-extend {imm,16'h0}: extend imm, then move it up 16 bits
        6'h0F: w_d = w_imm_sx << 16;
        default: w_ill = 1'b1;
      endcase
    end
  end

`ifdef OVERFLOW_TRAP_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign differs from the first operand.
  logic w_ovf;
  always_comb begin
    w_ovf = 1'b0;
    if (w_op == 6'h00 && w_funct == 6'h20)
      w_ovf = (r_s[M] == r_t[M]) && (w_add[M] != r_s[M]);
    else if (w_op == 6'h00 && w_funct == 6'h22)
      w_ovf = (r_s[M] != r_t[M]) && (w_sub[M] != r_s[M]);
    else if (w_op == 6'h08)
      w_ovf = (r_s[M] == w_imm_sx[M]) && (w_addi[M] != r_s[M]);
  end
  assign w_trap = w_ovf;
`else
  assign w_trap = 1'b0;
`endif

  assign w_we = (r_state == S_WB) && (r_dest5 != 5'd0) && in_range(r_dest5)
              && !r_ill && !r_trp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_d      <= '0;
      r_dest5  <= '0;
      r_ill    <= 1'b0;
      r_trp    <= 1'b0;
      ack_prev <= 1'b0;
      DOR      <= 1'b0;
      data_out <= '0;
      dest_out <= '0;
      illegal  <= 1'b0;
      trap     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (DIR) begin
          r_instr  <= data_in;
          ack_prev <= 1'b1;
          r_state  <= S_FETCH;
        end
        S_FETCH: begin
          ack_prev <= 1'b0;
          r_s      <= in_range(w_rs) ? r_rf[to_idx(w_rs)] : '0;
          r_t      <= in_range(w_rt) ? r_rf[to_idx(w_rt)] : '0;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_d     <= w_d;
          r_dest5 <= w_dest5;
          r_ill   <= w_ill;
          r_trp   <= w_trap;
          r_state <= S_WB;
        end
        S_WB: begin
          data_out <= r_d;
          dest_out <= to_idx(r_dest5);
          illegal  <= r_ill;
          trap     <= r_trp;
          DOR      <= 1'b1;
          r_state  <= S_WAIT;
        end
        S_WAIT: if (ack_from_next) begin
          DOR     <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (w_we) begin
      r_rf[to_idx(r_dest5)] <= r_d;
    end
  end

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_rf[dbg_raddr];

endmodule
